// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_seq
// Brief    : Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
//            It computes one quotient bit per cycle and returns
//            {remainder, quotient}. EX stays stalled until the result is ready.
//            Optional macro: DIV_BYZERO_FLAG_EN adds the byzero_o output.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o,
   output logic                  stallreq_o
`ifdef DIV_BYZERO_FLAG_EN
   ,
   output logic                  byzero_o
`endif
);

   localparam int                  c_CNT_W = $clog2(DATA_W) + 1;
   // The final iteration is the one that starts with this count; it also
   // writes the sign-corrected result so DONE is reached without an extra cycle.
   localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BYZERO = 2'd1,
      S_RUN    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              r_state;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0]   r_rem;      // partial remainder
   logic [DATA_W-1:0]   r_quo;      // dividend bits shifting out, quotient bits shifting in
   logic [DATA_W-1:0]   r_div;      // divisor magnitude
   logic                r_neg_q;    // quotient must be negated at the end
   logic                r_neg_r;    // remainder must be negated at the end

   logic [DATA_W-1:0]   w_abs1;
   logic [DATA_W-1:0]   w_abs2;
   logic [DATA_W:0]     w_trial;
   logic [DATA_W:0]     w_diff;
   logic [DATA_W-1:0]   w_rem_nxt;
   logic [DATA_W-1:0]   w_quo_nxt;
   logic [DATA_W-1:0]   w_rem_fix;
   logic [DATA_W-1:0]   w_quo_fix;

   // Operand magnitudes and one restoring step of the datapath
   always_comb begin
      w_abs1    = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
      w_abs2    = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
      w_trial   = {r_rem, r_quo[DATA_W-1]};
      w_diff    = w_trial - {1'b0, r_div};
      // A negative difference (MSB set) restores the shifted remainder.
      w_rem_nxt = w_diff[DATA_W] ? w_trial[DATA_W-1:0] : w_diff[DATA_W-1:0];
      w_quo_nxt = {r_quo[DATA_W-2:0], ~w_diff[DATA_W]};
      // Two's-complement wrap is intended: MIN / -1 yields MIN with remainder 0.
      w_quo_fix = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
      w_rem_fix = r_neg_r ? (~w_rem_nxt + 1'b1) : w_rem_nxt;
   end

   // EX is held while it requests an op that has not completed and is not being flushed
   always_comb begin
      stallreq_o = start_i & ~ready_o & ~annul_i;
   end

   // Sequencer state, iteration datapath and registered result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
         byzero_o <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               ready_o  <= 1'b0;
               result_o <= '0;
`ifdef DIV_BYZERO_FLAG_EN
               byzero_o <= 1'b0;
`endif
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     r_state <= S_BYZERO;
                  end else begin
                     r_state <= S_RUN;
                     r_rem   <= '0;
                     r_quo   <= w_abs1;
                     r_div   <= w_abs2;
                     r_neg_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                     r_neg_r <= signed_div_i & opdata1_i[DATA_W-1];
                     r_cnt   <= '0;
                  end
               end
            end

            S_BYZERO: begin
               // Flush has no effect here; the zero result is always delivered.
               r_state  <= S_DONE;
               result_o <= '0;
               ready_o  <= 1'b1;
`ifdef DIV_BYZERO_FLAG_EN
               byzero_o <= 1'b1;
`endif
            end

            S_RUN: begin
               if (annul_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_rem <= w_rem_nxt;
                  r_quo <= w_quo_nxt;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == c_LAST) begin
                     r_state  <= S_DONE;
                     result_o <= {w_rem_fix, w_quo_fix};
                     ready_o  <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               // Hold the result until EX drops its request; a held start is never a new op.
               if (!start_i) begin
                  r_state  <= S_IDLE;
                  result_o <= '0;
                  ready_o  <= 1'b0;
`ifdef DIV_BYZERO_FLAG_EN
                  byzero_o <= 1'b0;
`endif
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_seq
// Brief    : Scoreboard bench for div_seq. Issued ops push the expected
//            result and latency; a monitor pops on each rising ready_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           signed_div_i;
   logic [W-1:0]   opdata1_i;
   logic [W-1:0]   opdata2_i;
   logic           start_i;
   logic           annul_i;
   logic [2*W-1:0] result_o;
   logic           ready_o;
   logic           stallreq_o;
`ifdef DIV_BYZERO_FLAG_EN
   logic           byzero_o;
`endif

   div_seq #(.DATA_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .stallreq_o   (stallreq_o)
`ifdef DIV_BYZERO_FLAG_EN
      ,
      .byzero_o     (byzero_o)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] res;
      logic        bz;
      int          issue;
      int          lat;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer division, truncating toward zero, low W bits kept.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      longint x, y, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = longint'({32'd0, a});
         y = longint'({32'd0, b});
      end
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
   endfunction

   // Monitor: stall equation, result delivery, latency and hold stability
   logic        prev_ready = 1'b0;
   logic [63:0] hold_res   = 64'd0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         check("stallreq", 64'(stallreq_o), 64'(start_i & ~ready_o & ~annul_i));
         if (ready_o && !prev_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_ready", 64'(ready_o), 64'd0);
            end else begin
               e = sb.pop_front();
               check("result", result_o, e.res);
               check("latency", 64'(cyc - e.issue), 64'(e.lat));
`ifdef DIV_BYZERO_FLAG_EN
               check("byzero", 64'(byzero_o), 64'(e.bz));
`endif
               hold_res = e.res;
            end
         end else if (ready_o) begin
            check("hold_result", result_o, hold_res);
         end
`ifdef DIV_BYZERO_FLAG_EN
         if (!ready_o) check("byzero_idle", 64'(byzero_o), 64'd0);
`endif
      end
      prev_ready = ready_o;
   end

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit push);
      exp_t e;
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = s;
      start_i      = 1'b1;
      if (push) begin
         e.res   = ref_div(a, b, s);
         e.bz    = (b == 32'd0);
         e.issue = cyc;
         e.lat   = (b == 32'd0) ? 2 : W + 1;
         sb.push_back(e);
      end
   endtask

   // Waits for ready, holds start for a while in DONE, then releases it
   task automatic finish_op(input int hold);
      int n = 0;
      @(posedge clk); #1;
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom);
      while (!ready_o && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ready_o) check("ready_timeout", 64'(ready_o), 64'd1);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      check("ready_still_high", 64'(ready_o), 64'd1);
      start_i = 1'b0;
      @(posedge clk); #1;
      check("ready_drop", 64'(ready_o), 64'd0);
      check("result_drop", result_o, 64'd0);
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold);
      drive(a, b, s, 1'b1);
      finish_op(hold);
   endtask

   initial begin
      logic [31:0] a, b;
      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
      signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", 64'(ready_o), 64'd0);
      check("reset_result", result_o, 64'd0);
`ifdef DIV_BYZERO_FLAG_EN
      check("reset_byzero", 64'(byzero_o), 64'd0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases, including wrap and divide-by-zero
      run_op(32'd100, 32'd7, 1'b0, 0);
      run_op(-32'sd7, 32'd2, 1'b1, 1);
      run_op(32'd7, -32'sd2, 1'b1, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
      run_op(32'd5, 32'd0, 1'b0, 1);
      run_op(32'hFFFF_FFF0, 32'd0, 1'b1, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
      run_op(32'd3, 32'hFFFF_FFFE, 1'b0, 0);
      run_op(-32'sd9, -32'sd4, 1'b1, 0);

      // Flush during RUN, then an immediate new op
      drive(32'd100, 32'd7, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      annul_i = 1'b1;
      @(posedge clk); #1;
      annul_i = 1'b0;
      check("annul_no_ready", 64'(ready_o), 64'd0);
      drive(32'd9, 32'd3, 1'b0, 1'b1);
      finish_op(0);

      // Start together with annul in IDLE is never accepted
      start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
      repeat (3) @(posedge clk);
      #1;
      start_i = 1'b0; annul_i = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("annul_idle_no_ready", 64'(ready_o), 64'd0);

      // Reset in the middle of RUN
      drive(32'd1000, 32'd3, 1'b0, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1; start_i = 1'b0;
      @(posedge clk); #1;
      check("midrst_ready", 64'(ready_o), 64'd0);
      check("midrst_result", result_o, 64'd0);
      check("midrst_stall", 64'(stallreq_o), 64'd0);
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("midrst_no_ready", 64'(ready_o), 64'd0);

      // Randomized ops
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = $urandom_range(1, 15);
            3:       b = -($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 200);
         run_op(a, b, 1'($urandom), $urandom_range(0, 2));
      end

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
